// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, default timing and FSM state encodings for the memory arbiter
package mem_arbiter_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int MEM_LATENCY_DEF = 2;
    localparam int STARVE_MAX_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_e;

endpackage

// File: rtl/mem_arbiter_latency_counter.sv
// mem_latency_counter: counts the cycles of one memory access and flags the last one
module mem_latency_counter #(
    parameter int LATENCY = mem_arbiter_pkg::MEM_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    import mem_arbiter_pkg::*;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [CW-1:0] cnt_q;

    // Restart at zero while no access is running, advance once per busy cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (load_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + CW'(1);
    end

    assign tc_o = cnt_q == CW'(LATENCY - 1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between the fetch port and the data port
module mem_arbiter #(
    parameter int WORD_SIZE   = mem_arbiter_pkg::WORD_SIZE,
    parameter int MEM_LATENCY = mem_arbiter_pkg::MEM_LATENCY_DEF,
    parameter int STARVE_MAX  = mem_arbiter_pkg::STARVE_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);
    import mem_arbiter_pkg::*;

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_e        state_q;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          data_win;
    logic          busy;
    logic          last_beat;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    mem_latency_counter #(.LATENCY(MEM_LATENCY)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (!busy),
        .en_i   (busy),
        .tc_o   (last_beat)
    );

    // Data wins unless the waiting fetch has already lost STARVE_MAX grants in a row
    always_comb begin
        data_win = (d_read || d_write) && !(i_req && starve_q == SW'(STARVE_MAX));
        starve_d = (i_req && data_win) ? ((starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1)) : '0;
    end

    // Arbitrate in IDLE, drive the memory for MEM_LATENCY cycles, then pulse the matching ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_data    <= '0;
            d_rdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    if (data_win) begin
                        state_q   <= BUSY_D;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_write <= d_write;
                        mem_read  <= !d_write;
                    end else if (i_req) begin
                        state_q  <= BUSY_I;
                        mem_addr <= i_addr;
                        mem_read <= 1'b1;
                    end
                end
                BUSY_I: if (last_beat) begin
                    i_data   <= mem_rdata;
                    mem_read <= 1'b0;
                    i_ready  <= 1'b1;
                    state_q  <= DONE_I;
                end
                BUSY_D: if (last_beat) begin
                    if (mem_read) d_rdata <= mem_rdata;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    d_ready   <= 1'b1;
                    state_q   <= DONE_D;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
